// File: rtl/scroll_buffer_if.sv
// Handshake bundle between the switch-entry/display side and scroll_buffer.
// The master drives the write/control strobes; the slave returns the display window and status.
interface scroll_buffer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PosW = $clog2(4 * DEPTH);

  logic            wr_en;
  logic [15:0]     wr_data;
  logic            clear;
  logic            pause;
  logic [31:0]     win;
  logic [CntW-1:0] word_count;
  logic            full;
  logic [PosW-1:0] scroll_pos;
  logic            step;

  modport master (
    output wr_en, wr_data, clear, pause,
    input  win, word_count, full, scroll_pos, step
  );

  modport slave (
    input  wr_en, wr_data, clear, pause,
    output win, word_count, full, scroll_pos, step
  );
endinterface

// File: rtl/scroll_buffer.sv
// Circular nibble message store with a prescaled scroll engine feeding an 8-digit hex display.
// Words are appended one per enter tick; the registered window advances one nibble per step.
module scroll_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TICK_M      = 100000000,
  parameter logic [31:0] DEFAULT_WIN = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  scroll_buffer_if.slave bus
);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PosW  = $clog2(4 * DEPTH);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned IdxW  = PosW + 2;
  localparam int unsigned PreW  = $clog2(TICK_M);

  typedef enum logic [0:0] {StEmpty, StScroll} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            step_q, step_d;
  logic [31:0]     win_q, win_d;

  logic            full;
  logic            tick;
  logic            do_wr;
  logic [PosW:0]   len;
  logic [PosW:0]   pos_inc;
  logic [IdxW-1:0] idx;
  logic [15:0]     word;
  logic [3:0]      nib;

  assign full    = (count_q == CntW'(DEPTH));
  assign len     = {count_q, 2'b00};
  assign pos_inc = {1'b0, pos_q} + (PosW + 1)'(1);
  assign tick    = (state_q == StScroll) && !bus.pause && (presc_q == PreW'(TICK_M - 1));
  assign do_wr   = bus.wr_en && !bus.clear && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      count_q <= '0;
      pos_q   <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      win_q   <= DEFAULT_WIN;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      win_q   <= win_d;
    end
  end

  // Message storage is deliberately not reset; word_count alone defines what is visible.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[count_q[AddrW-1:0]] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StEmpty;
    end else if ((state_q == StEmpty) && bus.wr_en) begin
      state_d = StScroll;
    end
  end

  // Prescaler and pos sit at zero throughout EMPTY, so the first write needs no extra restart.
  always_comb begin
    count_d = count_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    step_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
      pos_d   = '0;
      presc_d = '0;
    end else begin
      if ((state_q == StScroll) && !bus.pause) begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
      end
      if (tick) begin
        step_d = 1'b1;
        pos_d  = (pos_inc == len) ? '0 : pos_inc[PosW-1:0];
      end
      if (do_wr) begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  // pos < L and L >= 4, so pos+i < 3L: two conditional subtractions replace a modulo.
  always_comb begin
    win_d = DEFAULT_WIN;
    idx   = '0;
    word  = '0;
    nib   = '0;
    if (count_q != '0) begin
      for (int i = 0; i < 8; i++) begin
        idx = IdxW'(pos_q) + IdxW'(i);
        if (idx >= IdxW'(len)) idx = idx - IdxW'(len);
        if (idx >= IdxW'(len)) idx = idx - IdxW'(len);
        word = mem_q[idx[PosW-1:2]];
        unique case (idx[1:0])
          2'd0: nib = word[15:12];
          2'd1: nib = word[11:8];
          2'd2: nib = word[7:4];
          2'd3: nib = word[3:0];
        endcase
        win_d[31-4*i -: 4] = nib;
      end
    end
  end

  assign bus.win        = win_q;
  assign bus.word_count = count_q;
  assign bus.full       = full;
  assign bus.scroll_pos = pos_q;
  assign bus.step       = step_q;
endmodule
